bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter for the serial system bus; sits between two master_out_port instances and the shared bus mux.
- Takes each master's approval_request and issues approval_grant, arbitor_busy and bus_busy; drives the mux select that routes the granted master's tx lines to the slaves.
- Ends a tenure on request release, transaction completion (bus_done) or a watchdog timeout.

Parameters:
- TIMEOUT_CYCLES, 1024, max cycles one tenure may last; 0 disables the watchdog.
- CNT_W, 11, tenure counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  bus clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- m1_request  input  1  approval_request from master 1.
- m2_request  input  1  approval_request from master 2.
- bus_done  input  1  single-cycle pulse: current transaction finished (slave rx_done / master tx_done, ORed externally).
- m1_grant  output  1  approval_grant to master 1.
- m2_grant  output  1  approval_grant to master 2.
- arbitor_busy  output  1  high during the arbitration decision cycle.
- bus_busy  output  1  bus owned or handing over.
- master_sel  output  1  mux select: 0 = master 1, 1 = master 2.
- timeout_flag  output  1  one-cycle pulse when a tenure is killed by the watchdog.

Behaviour:
- All outputs registered.
- Reset (reset=0, asynchronous) forces state IDLE, counter 0, last-winner = master 2, and all outputs 0, including master_sel=0.
- Reset asserted mid-tenure takes effect immediately: grants drop without waiting for a clock edge.
- States: IDLE, ARBITRATE, GRANT1, GRANT2, RELEASE.
- IDLE: all outputs 0 except master_sel, which holds its last value.
  - If m1_request or m2_request is sampled high at edge k, go to ARBITRATE; arbitor_busy=1 after edge k.
- ARBITRATE (exactly 1 cycle, arbitor_busy=1, bus_busy=1): resample the requests.
  - Both requests low: return to IDLE.
  - Only one request high: grant that master.
  - Both high: master 1 wins (fixed priority).
  - Winner's state entered at edge k+1: its grant=1, master_sel updated, arbitor_busy=0, counter cleared.
- GRANTn: grant held, bus_busy=1, counter increments every cycle (saturating). Leave to RELEASE on the first edge where any of these holds:
  - (a) the granted master's request is low;
  - (b) bus_done=1;
  - (c) TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1. This pulses timeout_flag for one cycle and takes precedence in flagging when (a) or (b) coincide.
  - The other master's request is ignored while in GRANTn; there is no preemption.
- RELEASE (exactly 1 cycle): both grants 0, bus_busy=1 as a turnaround gap. Next state is always IDLE.
  - A still-asserted request is re-arbitrated from IDLE, giving a minimum 2 idle/arb cycles between tenures.
- bus_done outside GRANTn is ignored.
- m1_grant and m2_grant are never both 1 (mutual exclusion is a required invariant).
- Counter saturates at all-ones; it never wraps into a false timeout.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: tie in ARBITRATE goes to the master that did NOT win the previous tenure. The last-winner register updates on entry to GRANTn; reset value is master 2, so master 1 wins the first tie.
- Undefined: fixed priority, master 1 always wins ties; last-winner register absent.
- Single-request behaviour is identical either way.

Test Plan:
- Reset then m1_request=1 at edge 0 → arbitor_busy=1 after edge 0; m1_grant=1, master_sel=0, bus_busy=1 after edge 1. Drop request at edge 5 → RELEASE (grants 0, bus_busy=1) for one cycle, then all outputs 0.
- m1_request and m2_request both high together → m1 granted. Release via bus_done pulse → m1 still requesting, m2 still requesting → fixed priority: m1 again; with ARB_ROUND_ROBIN_EN: m2 granted, master_sel=1.
- TIMEOUT_CYCLES=8, m2_request held high, no bus_done → m2_grant high for exactly 8 cycles, timeout_flag pulses 1 cycle at release, re-grant after 2 cycles.
- m2 granted, m1_request raised mid-tenure → no preemption; m1_grant rises only after m2 releases plus RELEASE/IDLE/ARBITRATE cycles.
- Request pulsed 1 cycle only (low in ARBITRATE) → no grant issued; return to IDLE with arbitor_busy high for exactly one cycle.
- reset driven low mid-GRANT1 between clock edges → m1_grant, bus_busy, arbitor_busy, timeout_flag all 0 immediately; after reset=1, fresh arbitration behaves as after power-up.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the serial system bus: grants, mux select and tenure watchdog.
// Optional ARB_ROUND_ROBIN_EN: ties go to the master that did not win the previous tenure.
module bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_W          = 11
) (
   input  logic clk,
   input  logic reset,
   input  logic m1_request,
   input  logic m2_request,
   input  logic bus_done,
   output logic m1_grant,
   output logic m2_grant,
   output logic arbitor_busy,
   output logic bus_busy,
   output logic master_sel,
   output logic timeout_flag
);

   typedef enum logic [2:0] {
      StIdle,
      StArbitrate,
      StGrant1,
      StGrant2,
      StRelease
   } state_e;

   localparam logic [CNT_W-1:0] CntMax      = '1;
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam bit               WdogEn      = (TIMEOUT_CYCLES != 0);

   state_e           state;
   logic [CNT_W-1:0] count;
   logic             any_req;
   logic             tie_sel;
   logic             win_sel;
   logic             own_req;
   logic             wdog_hit;
   logic             tenure_end;

`ifdef ARB_ROUND_ROBIN_EN
   // 0 = master 1 won the last tenure, 1 = master 2
   logic last_winner;

   assign tie_sel = ~last_winner;
`else
   assign tie_sel = 1'b0;
`endif

   assign any_req    = m1_request | m2_request;
   assign own_req    = (state == StGrant1) ? m1_request : m2_request;
   assign wdog_hit   = WdogEn && (count == TimeoutLast);
   assign tenure_end = wdog_hit || !own_req || bus_done;

   always_comb begin
      win_sel = 1'b0;
      if (m1_request && m2_request) begin
         win_sel = tie_sel;
      end else begin
         win_sel = ~m1_request;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= StIdle;
         count        <= '0;
         m1_grant     <= 1'b0;
         m2_grant     <= 1'b0;
         arbitor_busy <= 1'b0;
         bus_busy     <= 1'b0;
         master_sel   <= 1'b0;
         timeout_flag <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_winner  <= 1'b1;
`endif
      end else begin
         timeout_flag <= 1'b0;
         unique case (state)
            StIdle: begin
               if (any_req) begin
                  state        <= StArbitrate;
                  arbitor_busy <= 1'b1;
                  bus_busy     <= 1'b1;
               end
            end
            StArbitrate: begin
               arbitor_busy <= 1'b0;
               if (!any_req) begin
                  state    <= StIdle;
                  bus_busy <= 1'b0;
               end else begin
                  state      <= win_sel ? StGrant2 : StGrant1;
                  count      <= '0;
                  master_sel <= win_sel;
                  m1_grant   <= ~win_sel;
                  m2_grant   <= win_sel;
`ifdef ARB_ROUND_ROBIN_EN
                  last_winner <= win_sel;
`endif
               end
            end
            StGrant1, StGrant2: begin
               // Saturate so a long tenure can never wrap into a false timeout
               if (count != CntMax) begin
                  count <= count + 1'b1;
               end
               if (tenure_end) begin
                  state        <= StRelease;
                  m1_grant     <= 1'b0;
                  m2_grant     <= 1'b0;
                  timeout_flag <= wdog_hit;
               end
            end
            StRelease: begin
               state    <= StIdle;
               bus_busy <= 1'b0;
            end
            default: begin
               state        <= StIdle;
               m1_grant     <= 1'b0;
               m2_grant     <= 1'b0;
               arbitor_busy <= 1'b0;
               bus_busy     <= 1'b0;
            end
         endcase
      end
   end

   grant_mutex: assert property (@(posedge clk) disable iff (!reset) !(m1_grant && m2_grant));

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: driver pushes hand-computed per-cycle outputs, monitor pops
// and compares after each rising edge.
module tb_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic m1_request;
   logic m2_request;
   logic bus_done;
   logic m1_grant;
   logic m2_grant;
   logic arbitor_busy;
   logic bus_busy;
   logic master_sel;
   logic timeout_flag;

   int checks   = 0;
   int failures = 0;

   logic [5:0] exp_q[$];
   string      name_q[$];

   bus_arbiter #(
      .TIMEOUT_CYCLES(8),
      .CNT_W         (11)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .m1_request  (m1_request),
      .m2_request  (m2_request),
      .bus_done    (bus_done),
      .m1_grant    (m1_grant),
      .m2_grant    (m2_grant),
      .arbitor_busy(arbitor_busy),
      .bus_busy    (bus_busy),
      .master_sel  (master_sel),
      .timeout_flag(timeout_flag)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] outs();
      return {m1_grant, m2_grant, arbitor_busy, bus_busy, master_sel, timeout_flag};
   endfunction

   // {m1_grant, m2_grant, arbitor_busy, bus_busy, master_sel, timeout_flag}
   function automatic logic [5:0] v(bit g1, bit g2, bit ab, bit bb, bit sel, bit to);
      return {g1, g2, ab, bb, sel, to};
   endfunction

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got g1g2 ab bb sel to=%b required=%b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [2:0] in, input logic [5:0] e, input string name);
      @(negedge clk);
      m1_request = in[2];
      m2_request = in[1];
      bus_done   = in[0];
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   // Monitor: one expected vector per rising edge, sampled 2 time units after it
   initial begin
      logic [5:0] e;
      string      n;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, outs(), e);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      bit s;
      reset      = 1'b0;
      m1_request = 1'b0;
      m2_request = 1'b0;
      bus_done   = 1'b0;
      #1;
      check("reset_state", outs(), 6'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Single request from master 1, released by dropping the request
      step(3'b100, v(0, 0, 1, 1, 0, 0), "t1_arb");
      step(3'b100, v(1, 0, 0, 1, 0, 0), "t1_grant");
      repeat (3) step(3'b100, v(1, 0, 0, 1, 0, 0), "t1_hold");
      step(3'b000, v(0, 0, 0, 1, 0, 0), "t1_release");
      step(3'b000, v(0, 0, 0, 0, 0, 0), "t1_idle");
      step(3'b000, v(0, 0, 0, 0, 0, 0), "t1_idle2");

      // Simultaneous requests, tenure ended by bus_done, then re-arbitration of the tie
      step(3'b110, v(0, 0, 1, 1, 0, 0), "t2_arb");
      step(3'b110, v(1, 0, 0, 1, 0, 0), "t2_tie_m1");
      step(3'b110, v(1, 0, 0, 1, 0, 0), "t2_hold");
      step(3'b111, v(0, 0, 0, 1, 0, 0), "t2_done_release");
      step(3'b110, v(0, 0, 0, 0, 0, 0), "t2_idle");
      step(3'b110, v(0, 0, 1, 1, 0, 0), "t2_rearb");
      step(3'b110, RrEn ? v(0, 1, 0, 1, 1, 0) : v(1, 0, 0, 1, 0, 0), "t2_second_tie");
      s = RrEn;
      step(3'b000, v(0, 0, 0, 1, s, 0), "t2_release");
      step(3'b000, v(0, 0, 0, 0, s, 0), "t2_idle_sel_hold");

      // Master 2 holds its request: watchdog ends the tenure after 8 granted cycles
      step(3'b010, v(0, 0, 1, 1, s, 0), "t3_arb");
      step(3'b010, v(0, 1, 0, 1, 1, 0), "t3_grant");
      repeat (7) step(3'b010, v(0, 1, 0, 1, 1, 0), "t3_hold");
      step(3'b010, v(0, 0, 0, 1, 1, 1), "t3_timeout");
      step(3'b010, v(0, 0, 0, 0, 1, 0), "t3_idle");
      step(3'b010, v(0, 0, 1, 1, 1, 0), "t3_rearb");
      step(3'b010, v(0, 1, 0, 1, 1, 0), "t3_regrant");

      // Master 1 requests during master 2's tenure: no preemption
      repeat (3) step(3'b110, v(0, 1, 0, 1, 1, 0), "t4_no_preempt");
      step(3'b100, v(0, 0, 0, 1, 1, 0), "t4_release");
      step(3'b100, v(0, 0, 0, 0, 1, 0), "t4_idle");
      step(3'b100, v(0, 0, 1, 1, 1, 0), "t4_arb");
      step(3'b100, v(1, 0, 0, 1, 0, 0), "t4_m1_grant");
      step(3'b000, v(0, 0, 0, 1, 0, 0), "t4_release2");
      step(3'b000, v(0, 0, 0, 0, 0, 0), "t4_idle2");

      // One-cycle request pulse: arbitration abandons, bus_done in idle ignored
      step(3'b100, v(0, 0, 1, 1, 0, 0), "t5_arb");
      step(3'b000, v(0, 0, 0, 0, 0, 0), "t5_abort");
      step(3'b000, v(0, 0, 0, 0, 0, 0), "t5_idle");
      step(3'b001, v(0, 0, 0, 0, 0, 0), "t5_done_ignored");

      // Asynchronous reset in the middle of a master 1 tenure
      step(3'b100, v(0, 0, 1, 1, 0, 0), "t6_arb");
      step(3'b100, v(1, 0, 0, 1, 0, 0), "t6_grant");
      step(3'b100, v(1, 0, 0, 1, 0, 0), "t6_hold");
      @(negedge clk);
      #2;
      reset      = 1'b0;
      m1_request = 1'b0;
      #1;
      check("t6_async_reset", outs(), 6'b0);
      @(posedge clk);
      #2;
      check("t6_reset_held", outs(), 6'b0);
      @(negedge clk);
      reset = 1'b1;
      step(3'b100, v(0, 0, 1, 1, 0, 0), "t6_post_arb");
      step(3'b100, v(1, 0, 0, 1, 0, 0), "t6_post_grant");
      step(3'b000, v(0, 0, 0, 1, 0, 0), "t6_post_release");
      step(3'b000, v(0, 0, 0, 0, 0, 0), "t6_post_idle");
      // First tie after reset goes to master 1 in either build
      step(3'b110, v(0, 0, 1, 1, 0, 0), "t6_tie_arb");
      step(3'b110, v(1, 0, 0, 1, 0, 0), "t6_tie_m1");
      step(3'b000, v(0, 0, 0, 1, 0, 0), "t6_tie_release");
      step(3'b000, v(0, 0, 0, 0, 0, 0), "t6_tie_idle");

      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
